// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the round-robin UART transmit arbiter.
// The arbiter connects through the slave modport; a requester model uses master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*DATA_W-1:0] req_byte;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       uart_tx_byte;
  logic                    uart_tx_rdy;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  modport slave (
    input  req, lock, req_byte,
    output ack, uart_tx_byte, uart_tx_rdy, grant_id, busy
  );

  modport master (
    output req, lock, req_byte,
    input  ack, uart_tx_byte, uart_tx_rdy, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of a busy-less UART transmitter: times each frame itself,
// holds the byte for the whole frame and keeps locked multi-byte messages contiguous.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = 10,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(FRAME_CYCLES);

  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic              lock_valid_q, lock_valid_d;
  logic [ID_W-1:0]   lock_owner_q, lock_owner_d;
  logic [ID_W-1:0]   grant_q,      grant_d;
  logic [DATA_W-1:0] byte_q,       byte_d;
  logic              rdy_q,        rdy_d;
  logic [N_REQ-1:0]  ack_q,        ack_d;

  logic [ID_W-1:0]   rr_sel;
  logic [ID_W-1:0]   rr_cand;
  int                rr_idx;
  logic [ID_W-1:0]   sel;
  logic              lock_hit;

  // Scan from the farthest candidate down so the one nearest rr_ptr is written last.
  always_comb begin
    rr_sel  = rr_ptr_q;
    rr_idx  = 0;
    rr_cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      rr_cand = ID_W'(rr_idx);
      if (bus.req[rr_cand]) rr_sel = rr_cand;
    end
  end

  // A held lock whose owner dropped req falls through to round-robin; the
  // launch then overwrites lock_valid with the new winner's lock bit.
  assign lock_hit = lock_valid_q && bus.req[lock_owner_q];
  assign sel      = lock_hit ? lock_owner_q : rr_sel;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    grant_d      = grant_q;
    byte_d       = byte_q;
    rdy_d        = 1'b0;
    ack_d        = '0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (|bus.req) begin
      byte_d       = bus.req_byte[int'(sel)*DATA_W +: DATA_W];
      rdy_d        = 1'b1;
      ack_d        = N_REQ'(1) << sel;
      grant_d      = sel;
      cnt_d        = CNT_W'(FRAME_CYCLES - 1);
      rr_ptr_d     = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);
      lock_valid_d = bus.lock[sel];
      lock_owner_d = sel;
    end
  end

  // Reset loads a full guard interval: the UART has no reset and may still be mid-frame.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= CNT_W'(FRAME_CYCLES - 1);
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      grant_q      <= '0;
      byte_q       <= '0;
      rdy_q        <= 1'b0;
      ack_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      grant_q      <= grant_d;
      byte_q       <= byte_d;
      rdy_q        <= rdy_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.uart_tx_byte = byte_q;
  assign bus.uart_tx_rdy  = rdy_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (cnt_q != '0);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: guard interval, round-robin order, lock
// handling, mid-frame requests, idle latency and mid-frame reset.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int F    = 10;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .FRAME_CYCLES(F), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;
  logic prev_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse invariants: rdy never on two consecutive cycles, ack one-hot and coincident with rdy.
  always @(negedge clk) begin
    if (prev_rdy && bus.uart_tx_rdy) viol++;
    if (!$onehot0(bus.ack)) viol++;
    if ((bus.ack != '0) != bus.uart_tx_rdy) viol++;
    prev_rdy = bus.uart_tx_rdy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic l, input logic [W-1:0] b);
    bus.req[i]            = r;
    bus.lock[i]           = l;
    bus.req_byte[i*W +: W] = b;
  endtask

  // Returns the number of edges until rdy is observed (budget+1 if it never comes).
  task automatic wait_rdy(input int budget, output int n);
    n = 0;
    forever begin
      step();
      n++;
      if (bus.uart_tx_rdy) break;
      if (n >= budget) begin
        n = budget + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.lock     = '0;
    bus.req_byte = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step();
    check("rst_rdy",   32'(bus.uart_tx_rdy),  32'd0);
    check("rst_ack",   32'(bus.ack),          32'd0);
    check("rst_byte",  32'(bus.uart_tx_byte), 32'd0);
    check("rst_grant", 32'(bus.grant_id),     32'd0);
    check("rst_busy",  32'(bus.busy),         32'd1);
    step();
    rst_n = 1'b1;
  endtask

  int n;
  int busy_cnt;
  int bad;
  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req      = '0;
    bus.lock     = '0;
    bus.req_byte = '0;

    // 1: guard interval after reset, then one frame of 0xA5
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'hA5);
    wait_rdy(30, n);
    check("t1_guard",  32'(n),                F);
    check("t1_ack",    32'(bus.ack),          32'b0001);
    check("t1_byte",   32'(bus.uart_tx_byte), 32'hA5);
    check("t1_grant",  32'(bus.grant_id),     32'd0);
    set_req(0, 1'b0, 1'b0, 8'h00);
    busy_cnt = int'(bus.busy);
    bad = 0;
    for (int k = 0; k < F - 1; k++) begin
      step();
      busy_cnt += int'(bus.busy);
      if (bus.uart_tx_byte !== 8'hA5 || bus.uart_tx_rdy) bad++;
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    check("t1_byte_hold",   32'(bad),      32'd0);
    check("t1_idle_busy",   32'(bus.busy), 32'd0);

    // 2: all four requesting, round-robin 0,1,2,3,0 every F cycles
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      wait_rdy(30, n);
      check("t2_gap",   32'(n),                F);
      check("t2_grant", 32'(bus.grant_id),     32'(exp_g[k]));
      check("t2_ack",   32'(bus.ack),          32'(1 << exp_g[k]));
      check("t2_byte",  32'(bus.uart_tx_byte), 32'(8'h10 + exp_g[k]));
    end

    // 3: requester 2 locks "ABC" while requester 1 waits
    do_reset();
    set_req(2, 1'b1, 1'b1, 8'h41);
    wait_rdy(30, n);
    check("t3_grant_a", 32'(bus.grant_id),     32'd2);
    check("t3_byte_a",  32'(bus.uart_tx_byte), 32'h41);
    set_req(2, 1'b1, 1'b1, 8'h42);
    set_req(1, 1'b1, 1'b0, 8'h31);
    wait_rdy(30, n);
    check("t3_gap_b",   32'(n),                F);
    check("t3_grant_b", 32'(bus.grant_id),     32'd2);
    check("t3_byte_b",  32'(bus.uart_tx_byte), 32'h42);
    set_req(2, 1'b1, 1'b0, 8'h43);
    wait_rdy(30, n);
    check("t3_gap_c",   32'(n),                F);
    check("t3_grant_c", 32'(bus.grant_id),     32'd2);
    check("t3_byte_c",  32'(bus.uart_tx_byte), 32'h43);
    set_req(2, 1'b0, 1'b0, 8'h00);
    wait_rdy(30, n);
    check("t3_grant_1", 32'(bus.grant_id),     32'd1);
    check("t3_byte_1",  32'(bus.uart_tx_byte), 32'h31);

    // 4: locked owner drops req -> round-robin to 0; later req[3] must not regain the lock
    do_reset();
    set_req(3, 1'b1, 1'b1, 8'h77);
    wait_rdy(30, n);
    check("t4_grant_3", 32'(bus.grant_id), 32'd3);
    set_req(3, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h55);
    set_req(1, 1'b1, 1'b0, 8'h66);
    wait_rdy(30, n);
    check("t4_grant_0", 32'(bus.grant_id),     32'd0);
    check("t4_byte_0",  32'(bus.uart_tx_byte), 32'h55);
    set_req(0, 1'b0, 1'b0, 8'h00);
    set_req(3, 1'b1, 1'b0, 8'h78);
    wait_rdy(30, n);
    check("t4_grant_1", 32'(bus.grant_id), 32'd1);

    // 5: mid-frame request waits for cnt==0; idle request has 1-cycle latency
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h01);
    wait_rdy(30, n);
    set_req(0, 1'b0, 1'b0, 8'h00);
    repeat (5) step();
    set_req(1, 1'b1, 1'b0, 8'h22);
    wait_rdy(30, n);
    check("t5_wait",    32'(n),                32'd5);
    check("t5_grant",   32'(bus.grant_id),     32'd1);
    check("t5_byte",    32'(bus.uart_tx_byte), 32'h22);
    set_req(1, 1'b0, 1'b0, 8'h00);
    bad = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (bus.uart_tx_rdy) bad++;
    end
    check("t5_idle_rdy",  32'(bad),      32'd0);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    set_req(2, 1'b1, 1'b0, 8'h33);
    wait_rdy(30, n);
    check("t5_latency", 32'(n),            32'd1);
    check("t5_grant2",  32'(bus.grant_id), 32'd2);

    // 6: reset at cnt==5 clears outputs at once and restarts the guard interval
    do_reset();
    set_req(2, 1'b1, 1'b0, 8'h5A);
    wait_rdy(30, n);
    check("t6_grant", 32'(bus.grant_id), 32'd2);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdy",   32'(bus.uart_tx_rdy),  32'd0);
    check("t6_rst_ack",   32'(bus.ack),          32'd0);
    check("t6_rst_byte",  32'(bus.uart_tx_byte), 32'd0);
    check("t6_rst_grant", 32'(bus.grant_id),     32'd0);
    check("t6_rst_busy",  32'(bus.busy),         32'd1);
    step();
    rst_n = 1'b1;
    wait_rdy(30, n);
    check("t6_guard",      32'(n),                F);
    check("t6_byte_after", 32'(bus.uart_tx_byte), 32'h5A);

    step();
    check("pulse_invariants", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single-cycle-per-bit UART transmitter among N_REQ byte requesters with round-robin arbitration.
- The transmitter takes a one-cycle tx_rdy pulse and then reads tx_byte live for the following frame cycles. It has no busy output.
- This block therefore times each frame itself, holds the byte stable for the whole frame, and pulses tx_rdy only when the transmitter is idle.
- An optional per-requester lock keeps multi-byte messages contiguous on the line.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must equal the UART tx_byte width
FRAME_CYCLES, 10, clocks per frame (start + 8 data + stop); must be >= 10
ID_W, $clog2(N_REQ), width of grant_id

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request; hold high with stable byte until ack
lock  in  N_REQ  per-requester lock; sampled at launch
req_byte  in  N_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
ack  out  N_REQ  one-cycle pulse; byte of requester i accepted
uart_tx_byte  out  DATA_W  to UART tx_byte; held between launches
uart_tx_rdy  out  1  to UART tx_rdy; one-cycle pulse per frame
grant_id  out  ID_W  index of requester owning the current/last frame
busy  out  1  frame in flight (cnt != 0)

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, uart_tx_rdy=0, uart_tx_byte=0, grant_id=0, rr_ptr=0, lock_valid=0.
  - cnt=FRAME_CYCLES-1 and busy=1. The UART has no reset and may be mid-frame, so the first launch comes no earlier than FRAME_CYCLES cycles after release.
- Frame counter cnt:
  - Decrements by 1 on each edge while nonzero.
  - Launch is permitted only at an edge where cnt==0.
- Launch edge (cnt==0 and |req):
  - Select requester sel.
  - Registered updates: uart_tx_byte<=req_byte[sel], uart_tx_rdy<=1, ack[sel]<=1, grant_id<=sel, cnt<=FRAME_CYCLES-1, rr_ptr<=sel+1 mod N_REQ.
  - Record lock_valid<=lock[sel] and lock_owner<=sel.
- Pulses: uart_tx_rdy and ack clear on the next edge. They are never high two consecutive cycles.
- Cadence: with continuous demand, uart_tx_rdy pulses exactly every FRAME_CYCLES cycles.
- Byte hold: uart_tx_byte changes only at launch edges, so it is constant for the full frame.
- Selection order at a launch:
  1. If lock_valid and req[lock_owner]=1: sel=lock_owner, regardless of rr_ptr.
  2. If lock_valid but req[lock_owner]=0: lock is released (lock_valid<=0) and round-robin applies.
  3. Round-robin: the first set req scanning rr_ptr, rr_ptr+1, ... wrapping at N_REQ.
- Lock is sampled only at launch. Changing lock mid-frame has no effect until the next launch. Deassert lock with the last byte of a message.
- No request at cnt==0:
  - cnt stays 0, outputs hold and no pulse is issued.
  - The next launch occurs on the first edge where any req is sampled high, giving a 1-cycle request-to-rdy latency.
- Requests during a frame are not acked. They wait for cnt==0.
- Requester handshake:
  - After ack a requester may keep req high and present its next byte from the following cycle.
  - That byte is not sampled before the next launch edge.
- Simultaneous requests: exactly one ack per launch. ack is always one-hot or zero.
- Mid-frame reset: outputs return to reset values immediately, and the guard interval (cnt=FRAME_CYCLES-1) applies after release.

Test Plan:
- Reset release, req[0]=1 with 0xA5 -> no uart_tx_rdy for the first FRAME_CYCLES cycles; then one rdy pulse with ack[0] the same cycle, uart_tx_byte=0xA5 stable for 10 cycles, busy=1 for 9 cycles.
- req[3:0]=4'b1111 held, bytes 0x10..0x13 -> rdy every 10 cycles, grant order 0,1,2,3,0; ack one-hot, coincident with rdy.
- Requester 2 with lock=1 sends 0x41,0x42,0x43 (lock=0 on 0x43) while req[1] is held -> grants 2,2,2 then 1; the line serialises "ABC" contiguously.
- Locked requester drops req at a launch point while req[0]=1 -> lock released, grant to round-robin winner 0.
- req[1] pulsed at cnt==4 mid-frame -> no ack until cnt==0; launch on the next edge after cnt reaches 0.
- rst_n low at cnt==5 with rdy history -> outputs immediately 0, busy=1; first launch exactly FRAME_CYCLES edges after release.
